// File: rtl/uart_word_bridge.sv
// Word-wide bridge onto an AXI-Lite UART: queued TX words go out MSB first, one byte per register write.
// RX polls the status register, then reads and accumulates WORD_BYTES data bytes into one word.

module uart_word_bridge #(
  parameter int          WORD_BYTES = 4,
  parameter int          TXQ_DEPTH  = 4,
  parameter logic [31:0] RX_ADDR    = 32'h0,
  parameter logic [31:0] TX_ADDR    = 32'h4,
  parameter logic [31:0] STAT_ADDR  = 32'h8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        wenable,
  input  logic [31:0] wdata,
  output logic        wfull,
  output logic        wdone,
  input  logic        renable,
  output logic        rbusy,
  output logic        rdone,
  output logic [31:0] rdata,
  output logic [31:0] uart_awaddr,
  output logic        uart_awvalid,
  input  logic        uart_awready,
  output logic [31:0] uart_wdata,
  output logic [3:0]  uart_wstrb,
  output logic        uart_wvalid,
  input  logic        uart_wready,
  input  logic [1:0]  uart_bresp,
  input  logic        uart_bvalid,
  output logic        uart_bready,
  output logic [31:0] uart_araddr,
  output logic        uart_arvalid,
  input  logic        uart_arready,
  input  logic [31:0] uart_rdata,
  input  logic [1:0]  uart_rresp,
  input  logic        uart_rvalid,
  output logic        uart_rready
);

  localparam int         QW    = (TXQ_DEPTH > 1) ? $clog2(TXQ_DEPTH) : 1;
  localparam int         QCW   = QW + 1;
  localparam int         MSB   = 8 * WORD_BYTES - 1;
  localparam logic [1:0] LAST  = 2'(WORD_BYTES - 1);
  localparam logic [QW:0] QFULL = QCW'(TXQ_DEPTH);

  typedef enum logic [1:0] {T_IDLE, T_SEND, T_RESP} tx_state_t;
  typedef enum logic [1:0] {R_IDLE, R_STAT, R_DATA, R_DONE} rx_state_t;

  logic [31:0]   r_q [TXQ_DEPTH];
  logic [QW-1:0] r_wptr, r_rptr;
  logic [QW:0]   r_count;
  logic          w_empty, w_full, w_push, w_pop;
  logic [31:0]   w_q_head;

  tx_state_t   r_tx_state, w_tx_next;
  logic [31:0] r_tx_shift, w_tx_shl;
  logic [1:0]  r_tx_cnt;
  logic [7:0]  r_wbyte;
  logic        r_awvalid, r_wvalid, r_bready, r_wdone;
  logic        w_aw_done, w_w_done;

  rx_state_t   r_rx_state, w_rx_next;
  logic [1:0]  r_rx_cnt;
  logic [31:0] r_acc, r_rdata, r_araddr;
  logic        r_arvalid, r_rready, r_rdone, r_rbusy;
  logic        w_r_hs;
  logic        w_unused;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == QFULL);
  assign w_pop    = (r_tx_state == T_IDLE) && !w_empty;
  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign w_push   = wenable && (!w_full || w_pop);
  assign w_q_head = r_q[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) r_q[r_wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  assign w_tx_shl  = r_tx_shift << 8;
  assign w_aw_done = !r_awvalid || uart_awready;
  assign w_w_done  = !r_wvalid || uart_wready;

  always_ff @(posedge clk) begin
    if (!rstn) r_tx_state <= T_IDLE;
    else       r_tx_state <= w_tx_next;
  end

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      T_IDLE: if (!w_empty) w_tx_next = T_SEND;
      T_SEND: if (w_aw_done && w_w_done) w_tx_next = T_RESP;
      T_RESP: if (uart_bvalid)
                w_tx_next = (!uart_bresp[1] && r_tx_cnt == 2'd0) ? T_IDLE : T_SEND;
      default: w_tx_next = T_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_tx_shift <= '0;
      r_tx_cnt   <= '0;
      r_wbyte    <= '0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_bready   <= 1'b0;
      r_wdone    <= 1'b0;
    end else begin
      r_wdone <= 1'b0;
      case (r_tx_state)
        T_IDLE: if (!w_empty) begin
          r_tx_shift <= w_q_head;
          r_tx_cnt   <= LAST;
          r_wbyte    <= w_q_head[MSB -: 8];
          r_awvalid  <= 1'b1;
          r_wvalid   <= 1'b1;
          r_bready   <= 1'b1;
        end
        T_SEND: begin
          if (uart_awready) r_awvalid <= 1'b0;
          if (uart_wready)  r_wvalid  <= 1'b0;
        end
        T_RESP: if (uart_bvalid) begin
          if (uart_bresp[1]) begin
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
          end else if (r_tx_cnt == 2'd0) begin
            r_bready <= 1'b0;
            r_wdone  <= 1'b1;
          end else begin
            r_tx_shift <= w_tx_shl;
            r_tx_cnt   <= r_tx_cnt - 1'b1;
            r_wbyte    <= w_tx_shl[MSB -: 8];
            r_awvalid  <= 1'b1;
            r_wvalid   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_r_hs = uart_rvalid && r_rready;

  always_ff @(posedge clk) begin
    if (!rstn) r_rx_state <= R_IDLE;
    else       r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      R_IDLE: if (renable) w_rx_next = R_STAT;
      R_STAT: if (w_r_hs && !uart_rresp[1] && uart_rdata[0]) w_rx_next = R_DATA;
      R_DATA: if (w_r_hs && !uart_rresp[1])
                w_rx_next = (r_rx_cnt == LAST) ? R_DONE : R_STAT;
      R_DONE: w_rx_next = R_IDLE;
      default: w_rx_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rx_cnt  <= '0;
      r_acc     <= '0;
      r_rdata   <= '0;
      r_araddr  <= STAT_ADDR;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_rdone   <= 1'b0;
      r_rbusy   <= 1'b0;
    end else begin
      r_rdone <= 1'b0;
      if (r_arvalid && uart_arready) r_arvalid <= 1'b0;
      if (w_r_hs)                    r_rready  <= 1'b0;
      // Every non-final response below re-arms AR and R together, keeping one read outstanding.
      case (r_rx_state)
        R_IDLE: if (renable) begin
          r_rx_cnt  <= '0;
          r_acc     <= '0;
          r_rbusy   <= 1'b1;
          r_araddr  <= STAT_ADDR;
          r_arvalid <= 1'b1;
          r_rready  <= 1'b1;
        end
        R_STAT: if (w_r_hs) begin
          r_arvalid <= 1'b1;
          r_rready  <= 1'b1;
          if (!uart_rresp[1] && uart_rdata[0]) r_araddr <= RX_ADDR;
        end
        R_DATA: if (w_r_hs) begin
          if (uart_rresp[1]) begin
            r_arvalid <= 1'b1;
            r_rready  <= 1'b1;
          end else begin
            r_acc    <= {r_acc[23:0], uart_rdata[7:0]};
            r_rx_cnt <= r_rx_cnt + 1'b1;
            if (r_rx_cnt != LAST) begin
              r_araddr  <= STAT_ADDR;
              r_arvalid <= 1'b1;
              r_rready  <= 1'b1;
            end
          end
        end
        R_DONE: begin
          r_rdata <= r_acc;
          r_rdone <= 1'b1;
          r_rbusy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign w_unused     = ^{uart_bresp[0], uart_rresp[0], uart_rdata[31:8]};

  assign wfull        = w_full;
  assign wdone        = r_wdone;
  assign rbusy        = r_rbusy;
  assign rdone        = r_rdone;
  assign rdata        = r_rdata;
  assign uart_awaddr  = TX_ADDR;
  assign uart_awvalid = r_awvalid;
  assign uart_wdata   = {24'h0, r_wbyte};
  assign uart_wstrb   = 4'b0001;
  assign uart_wvalid  = r_wvalid;
  assign uart_bready  = r_bready;
  assign uart_araddr  = r_araddr;
  assign uart_arvalid = r_arvalid;
  assign uart_rready  = r_rready;

endmodule

// File: tb/tb_uart_word_bridge.sv
// Two bridges (4-byte and 2-byte words) against scripted AXI-Lite UART slaves.
// Stimulus queues expected bytes/words; the negedge slave/monitor pops and compares.

module tb_uart_word_bridge;

  localparam logic [31:0] RXA = 32'h0, TXA = 32'h4, STA = 32'h8;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  resp;
    logic [31:0] data;
  } rd_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        wenable[2], wfull[2], wdone[2], renable[2], rbusy[2], rdone[2];
  logic [31:0] wdata_in[2], rdata[2];
  logic [31:0] awaddr[2], wdata_ax[2], araddr[2], rdata_ax[2];
  logic [3:0]  wstrb[2];
  logic [1:0]  bresp[2], rresp[2];
  logic        awvalid[2], awready[2], wvalid[2], wready[2], bvalid[2], bready[2];
  logic        arvalid[2], arready[2], rvalid[2], rready[2];
  logic        b_stall[2];

  logic [7:0]  exp_tx[2][$];
  logic [1:0]  bresp_q[2][$];
  rd_t         rd_q[2][$];
  logic [31:0] exp_rd[2][$];

  bit  aw_got[2], w_got[2], ar_got[2];
  bit  hs_aw[2], hs_w[2], hs_b[2], hs_ar[2], hs_r[2];
  int  wdone_cnt[2], rdone_cnt[2];
  int  checks = 0, failures = 0;
  rd_t e;

  uart_word_bridge #(.WORD_BYTES(4), .TXQ_DEPTH(4)) u_dut0 (
    .clk(clk), .rstn(rstn), .wenable(wenable[0]), .wdata(wdata_in[0]), .wfull(wfull[0]),
    .wdone(wdone[0]), .renable(renable[0]), .rbusy(rbusy[0]), .rdone(rdone[0]), .rdata(rdata[0]),
    .uart_awaddr(awaddr[0]), .uart_awvalid(awvalid[0]), .uart_awready(awready[0]),
    .uart_wdata(wdata_ax[0]), .uart_wstrb(wstrb[0]), .uart_wvalid(wvalid[0]), .uart_wready(wready[0]),
    .uart_bresp(bresp[0]), .uart_bvalid(bvalid[0]), .uart_bready(bready[0]),
    .uart_araddr(araddr[0]), .uart_arvalid(arvalid[0]), .uart_arready(arready[0]),
    .uart_rdata(rdata_ax[0]), .uart_rresp(rresp[0]), .uart_rvalid(rvalid[0]), .uart_rready(rready[0]));

  uart_word_bridge #(.WORD_BYTES(2), .TXQ_DEPTH(4)) u_dut1 (
    .clk(clk), .rstn(rstn), .wenable(wenable[1]), .wdata(wdata_in[1]), .wfull(wfull[1]),
    .wdone(wdone[1]), .renable(renable[1]), .rbusy(rbusy[1]), .rdone(rdone[1]), .rdata(rdata[1]),
    .uart_awaddr(awaddr[1]), .uart_awvalid(awvalid[1]), .uart_awready(awready[1]),
    .uart_wdata(wdata_ax[1]), .uart_wstrb(wstrb[1]), .uart_wvalid(wvalid[1]), .uart_wready(wready[1]),
    .uart_bresp(bresp[1]), .uart_bvalid(bvalid[1]), .uart_bready(bready[1]),
    .uart_araddr(araddr[1]), .uart_arvalid(arvalid[1]), .uart_arready(arready[1]),
    .uart_rdata(rdata_ax[1]), .uart_rresp(rresp[1]), .uart_rvalid(rvalid[1]), .uart_rready(rready[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Handshakes seen at one negedge complete on the following posedge and are acted on next negedge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rstn) begin
        aw_got[i] = 0; w_got[i] = 0; ar_got[i] = 0;
        bvalid[i] = 1'b0; rvalid[i] = 1'b0;
      end else begin
        if (hs_aw[i]) aw_got[i] = 1;
        if (hs_w[i])  w_got[i]  = 1;
        if (hs_b[i])  bvalid[i] = 1'b0;
        if (hs_ar[i]) ar_got[i] = 1;
        if (hs_r[i])  rvalid[i] = 1'b0;
        if (aw_got[i] && w_got[i] && !bvalid[i] && !b_stall[i]) begin
          bvalid[i] = 1'b1;
          if (bresp_q[i].size() > 0) bresp[i] = bresp_q[i].pop_front();
          else                       bresp[i] = 2'b00;
          aw_got[i] = 0; w_got[i] = 0;
        end
        if (ar_got[i] && !rvalid[i]) begin
          rvalid[i] = 1'b1;
          if (rd_q[i].size() > 0) begin
            e = rd_q[i].pop_front();
            rresp[i] = e.resp; rdata_ax[i] = e.data;
          end else begin
            rresp[i] = 2'b00; rdata_ax[i] = '0;
          end
          ar_got[i] = 0;
        end
        if (i == 1) awready[i] = ~awready[i];
        else        awready[i] = 1'b1;
        if (wdone[i]) wdone_cnt[i]++;
        if (rdone[i]) begin
          rdone_cnt[i]++;
          chk($sformatf("rx%0d_rdone_expected", i), exp_rd[i].size() > 0, 1);
          if (exp_rd[i].size() > 0) chk($sformatf("rx%0d_rdata", i), rdata[i], exp_rd[i].pop_front());
          chk($sformatf("rx%0d_rbusy_at_rdone", i), rbusy[i], 0);
        end
      end
      hs_aw[i] = awvalid[i] && awready[i];
      hs_w[i]  = wvalid[i] && wready[i];
      hs_b[i]  = bvalid[i] && bready[i];
      hs_ar[i] = arvalid[i] && arready[i];
      hs_r[i]  = rvalid[i] && rready[i];
      if (hs_aw[i]) chk($sformatf("tx%0d_awaddr", i), awaddr[i], TXA);
      if (hs_w[i]) begin
        chk($sformatf("tx%0d_byte_expected", i), exp_tx[i].size() > 0, 1);
        if (exp_tx[i].size() > 0) chk($sformatf("tx%0d_wdata", i), wdata_ax[i], {24'h0, exp_tx[i].pop_front()});
        chk($sformatf("tx%0d_wstrb", i), {28'h0, wstrb[i]}, 32'h1);
      end
      if (hs_ar[i]) begin
        chk($sformatf("rx%0d_read_expected", i), rd_q[i].size() > 0, 1);
        if (rd_q[i].size() > 0) chk($sformatf("rx%0d_araddr", i), araddr[i], rd_q[i][0].addr);
      end
    end
  end

  task automatic exp_bytes(input int i, input logic [31:0] w, input int nb);
    for (int k = nb - 1; k >= 0; k--) exp_tx[i].push_back(w[8*k +: 8]);
  endtask

  task automatic drive_push(input int i, input logic [31:0] w);
    @(negedge clk); wenable[i] = 1'b1; wdata_in[i] = w;
    @(negedge clk); wenable[i] = 1'b0;
  endtask

  task automatic rd(input int i, input logic [31:0] a, input logic [1:0] r, input logic [31:0] d);
    rd_t t;
    t.addr = a; t.resp = r; t.data = d;
    rd_q[i].push_back(t);
  endtask

  task automatic wait_for(input bit rx, input int i, input int target, input string name);
    int n;
    n = 0;
    while (((rx ? rdone_cnt[i] : wdone_cnt[i]) < target) && (n < 3000)) begin
      @(negedge clk);
      n++;
    end
    chk(name, rx ? rdone_cnt[i] : wdone_cnt[i], target);
  endtask

  task automatic chk_reset(input int i, input string tag);
    chk({tag, "_wfull"},   wfull[i],   0);
    chk({tag, "_wdone"},   wdone[i],   0);
    chk({tag, "_rdone"},   rdone[i],   0);
    chk({tag, "_rbusy"},   rbusy[i],   0);
    chk({tag, "_rdata"},   rdata[i],   0);
    chk({tag, "_awvalid"}, awvalid[i], 0);
    chk({tag, "_wvalid"},  wvalid[i],  0);
    chk({tag, "_bready"},  bready[i],  0);
    chk({tag, "_arvalid"}, arvalid[i], 0);
    chk({tag, "_rready"},  rready[i],  0);
    chk({tag, "_awaddr"},  awaddr[i],  TXA);
    chk({tag, "_araddr"},  araddr[i],  STA);
    chk({tag, "_wstrb"},   {28'h0, wstrb[i]}, 32'h1);
    chk({tag, "_wdata"},   wdata_ax[i], 0);
  endtask

  initial begin
    logic [31:0] words[5];
    int n;
    rstn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wenable[i] = 1'b0; wdata_in[i] = '0; renable[i] = 1'b0; b_stall[i] = 1'b0;
      awready[i] = 1'b0; wready[i] = 1'b1; arready[i] = 1'b1;
      bvalid[i] = 1'b0; bresp[i] = 2'b00; rvalid[i] = 1'b0; rresp[i] = 2'b00; rdata_ax[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk_reset(0, "rst_d0");
    chk_reset(1, "rst_d1");
    rstn = 1'b1;

    // One word, immediate slave: A1 B2 C3 D4 then one wdone.
    exp_bytes(0, 32'hA1B2C3D4, 4);
    drive_push(0, 32'hA1B2C3D4);
    wait_for(0, 0, 1, "t1_wdone");

    // Third byte answered SLVERR once: C3 goes out twice, still one wdone.
    bresp_q[0].push_back(2'b00); bresp_q[0].push_back(2'b00); bresp_q[0].push_back(2'b10);
    exp_bytes(0, 32'hA1B2C3, 3);
    exp_bytes(0, 32'hC3D4, 2);
    drive_push(0, 32'hA1B2C3D4);
    wait_for(0, 0, 2, "t2_wdone");

    // Blocker word parks TX in T_RESP, then five back-to-back pushes: four fit, fifth dropped.
    b_stall[0] = 1'b1;
    exp_bytes(0, 32'hF0F1F2F3, 4);
    drive_push(0, 32'hF0F1F2F3);
    repeat (6) @(negedge clk);
    chk("t3_blocker_in_resp", bready[0] && !awvalid[0] && !wvalid[0], 1);
    words[0] = 32'h10111213; words[1] = 32'h20212223; words[2] = 32'h30313233;
    words[3] = 32'h40414243; words[4] = 32'h50515253;
    for (int k = 0; k < 4; k++) exp_bytes(0, words[k], 4);
    for (int k = 0; k < 5; k++) begin
      wenable[0] = 1'b1; wdata_in[0] = words[k];
      @(negedge clk);
      chk($sformatf("t3_wfull_after_push%0d", k + 1), wfull[0], (k >= 3));
    end
    wenable[0] = 1'b0;
    b_stall[0] = 1'b0;
    wait_for(0, 0, 7, "t3_wdone_total");

    // Status not-ready three times, error responses on a status and a data read, bytes 11 22 33 44.
    for (int k = 0; k < 3; k++) rd(0, STA, 2'b00, 32'hFFFF_FFFE);
    rd(0, STA, 2'b00, 32'h1); rd(0, RXA, 2'b00, 32'h11);
    rd(0, STA, 2'b10, 32'h1); rd(0, STA, 2'b00, 32'h1); rd(0, RXA, 2'b00, 32'h22);
    rd(0, STA, 2'b00, 32'h1); rd(0, RXA, 2'b10, 32'h99); rd(0, RXA, 2'b00, 32'hFFFF_FF33);
    rd(0, STA, 2'b00, 32'h1); rd(0, RXA, 2'b00, 32'h44);
    exp_rd[0].push_back(32'h11223344);
    @(negedge clk); renable[0] = 1'b1;
    @(negedge clk); renable[0] = 1'b0;
    chk("t4_rbusy_after_renable", rbusy[0], 1);
    renable[0] = 1'b1;
    @(negedge clk); renable[0] = 1'b0;
    wait_for(1, 0, 1, "t4_rdone");

    // Two-byte instance: TX and RX at the same time.
    exp_bytes(1, 32'hBEEF, 2);
    rd(1, STA, 2'b00, 32'h1); rd(1, RXA, 2'b00, 32'h5A);
    rd(1, STA, 2'b00, 32'h1); rd(1, RXA, 2'b00, 32'h6B);
    exp_rd[1].push_back(32'h00005A6B);
    @(negedge clk); wenable[1] = 1'b1; wdata_in[1] = 32'h1234BEEF; renable[1] = 1'b1;
    @(negedge clk); wenable[1] = 1'b0; renable[1] = 1'b0;
    wait_for(0, 1, 1, "t5_wdone");
    wait_for(1, 1, 1, "t5_rdone");

    // Reset while waiting in T_RESP: reset values everywhere and no wdone afterwards.
    b_stall[0] = 1'b1;
    exp_bytes(0, 32'hDE, 1);
    drive_push(0, 32'hDEADBEEF);
    n = 0;
    while (!(bready[0] && !awvalid[0] && !wvalid[0]) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reached_tresp", n < 50, 1);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset(0, "t6_rst_d0");
    chk_reset(1, "t6_rst_d1");
    b_stall[0] = 1'b0;
    rstn = 1'b1;
    repeat (30) @(negedge clk);
    chk("t6_no_wdone_after_reset", wdone_cnt[0], 7);

    chk("end_tx0_pending", exp_tx[0].size(), 0);
    chk("end_tx1_pending", exp_tx[1].size(), 0);
    chk("end_rd0_script_left", rd_q[0].size(), 0);
    chk("end_rd1_script_left", rd_q[1].size(), 0);
    chk("end_rdone0_count", rdone_cnt[0], 1);
    chk("end_rdone1_count", rdone_cnt[1], 1);
    chk("end_wdone1_count", wdone_cnt[1], 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
